verificar_pareja: RTL

VERIFICAR_PAREJA -- requirements
Module: verificar_pareja

---
 rtl/verificar_pareja.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/verificar_pareja.sv
// Pair checker for a 16-card memory game: scans the board, compares the first two face-up cards,
// marks a match or hides a mismatch after HOLD_CYCLES. Optional score counter under `PAIR_SCORE_EN`.
module verificar_pareja #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] arr_cards_in  [0:15],
    output logic [4:0] arr_cards_out [0:15],
    output logic       done,
    output logic       match,
    output logic       no_pair,
    output logic [3:0] pairs_found,
    output logic       all_matched
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SCAN    = 3'd1;
    localparam logic [2:0] S_COMPARE = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [2:0]    state_reg;
    logic [4:0]    board_reg     [0:15];
    logic [4:0]    cards_out_reg [0:15];
    logic [3:0]    scan_idx_reg;
    logic [3:0]    idx_a_reg;
    logic [3:0]    idx_b_reg;
    logic [1:0]    found_reg;
    logic          match_reg;
    logic          no_pair_reg;
    logic [CW-1:0] hold_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            scan_idx_reg <= '0;
            idx_a_reg    <= '0;
            idx_b_reg    <= '0;
            found_reg    <= '0;
            match_reg    <= 1'b0;
            no_pair_reg  <= 1'b0;
            hold_cnt_reg <= '0;
            for (int i = 0; i < 16; i++) begin
                board_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 16; i++) begin
                            board_reg[i] <= arr_cards_in[i];
                        end
                        scan_idx_reg <= '0;
                        idx_a_reg    <= '0;
                        idx_b_reg    <= '0;
                        found_reg    <= '0;
                        match_reg    <= 1'b0;
                        no_pair_reg  <= 1'b0;
                        hold_cnt_reg <= '0;
                        state_reg    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // Only the first two face-up cards take part; later ones pass through.
                    if (board_reg[scan_idx_reg][4:3] == 2'b01) begin
                        if (found_reg == 2'd0) begin
                            idx_a_reg <= scan_idx_reg;
                            found_reg <= 2'd1;
                        end else if (found_reg == 2'd1) begin
                            idx_b_reg <= scan_idx_reg;
                            found_reg <= 2'd2;
                        end
                    end
                    scan_idx_reg <= scan_idx_reg + 4'd1;
                    if (scan_idx_reg == 4'd15) begin
                        state_reg <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (found_reg != 2'd2) begin
                        no_pair_reg <= 1'b1;
                        state_reg   <= S_WRITE;
                    end else if (board_reg[idx_a_reg][2:0] == board_reg[idx_b_reg][2:0]) begin
                        board_reg[idx_a_reg][4:3] <= 2'b10;
                        board_reg[idx_b_reg][4:3] <= 2'b10;
                        match_reg                 <= 1'b1;
                        state_reg                 <= S_WRITE;
                    end else begin
                        hold_cnt_reg <= '0;
                        state_reg    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // The visible board is untouched here, so the player keeps seeing both cards.
                    if (hold_cnt_reg == CW'(HOLD_CYCLES - 1)) begin
                        board_reg[idx_a_reg][4:3] <= 2'b00;
                        board_reg[idx_b_reg][4:3] <= 2'b00;
                        state_reg                 <= S_WRITE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                S_WRITE: state_reg <= S_DONE;
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_out
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cards_out_reg[gi] <= '0;
                end else if (state_reg == S_WRITE) begin
                    cards_out_reg[gi] <= board_reg[gi];
                end
            end
            assign arr_cards_out[gi] = cards_out_reg[gi];
        end
    endgenerate

    assign done    = (state_reg == S_DONE);
    assign match   = done & match_reg;
    assign no_pair = done & no_pair_reg;

`ifdef PAIR_SCORE_EN
    logic [3:0] pairs_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pairs_reg <= '0;
        end else if ((state_reg == S_DONE) && match_reg && (pairs_reg != 4'd8)) begin
            pairs_reg <= pairs_reg + 4'd1;
        end
    end

    assign pairs_found = pairs_reg;
    assign all_matched = (pairs_reg == 4'd8);
`else
    assign pairs_found = 4'd0;
    assign all_matched = 1'b0;
`endif

endmodule
